des_round_ctrl: RTL

- Iterative DES sequencer: accepts one 64-bit block plus 56-bit key per transaction and runs the 16 Feistel rounds at one round per clock.
- Shares a single round-function datapath (expansion, key XOR, S-boxes, P) across all rounds instead of 16 unrolled copies.
- Owns the L/R state, the C/D key-schedule registers and the round counter.
- Block arrives post-IP and leaves pre-FP; the IP/FP permutations and PC1/PC2 sit in the surrounding wrapper and round datapath.

---
 rtl/des_pkg.sv | 20 ++
 rtl/des_key_rot.sv | 42 ++++
 rtl/des_round_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared constants and types for the iterative DES round controller.
// The per-round key-schedule shift table lives here so all users agree on it.
package des_pkg;

  localparam int DES_ROUNDS = 16;
  localparam int LR_W       = 32;
  localparam int CD_W       = 28;

  localparam logic [1:0] DES_SH [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_state_e;

endpackage

// File: rtl/des_key_rot.sv
// Combinational 28-bit key-half rotator: left or right by 0, 1 or 2 positions.
// With ALLOW_RIGHT=0 only the left rotator exists and dir_right is ignored.
module des_key_rot
  import des_pkg::*;
#(
  parameter bit ALLOW_RIGHT = 1'b1
) (
  input  logic [CD_W-1:0] din,
  input  logic [1:0]      amt,
  input  logic            dir_right,
  output logic [CD_W-1:0] dout
);

  logic [CD_W-1:0] rot_l;

  always_comb begin
    case (amt)
      2'd1:    rot_l = {din[CD_W-2:0], din[CD_W-1]};
      2'd2:    rot_l = {din[CD_W-3:0], din[CD_W-1:CD_W-2]};
      default: rot_l = din;
    endcase
  end

  if (ALLOW_RIGHT) begin : g_right
    logic [CD_W-1:0] rot_r;

    always_comb begin
      case (amt)
        2'd1:    rot_r = {din[0], din[CD_W-1:1]};
        2'd2:    rot_r = {din[1:0], din[CD_W-1:2]};
        default: rot_r = din;
      endcase
    end

    assign dout = dir_right ? rot_r : rot_l;
  end else begin : g_left_only
    logic unused_dir;
    assign unused_dir = dir_right;
    assign dout       = rot_l;
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES sequencer: one Feistel round per clock through a shared round datapath.
// Define DES_ROUND_CTRL_DECRYPT_EN to honour in_decrypt (right-rotating key schedule).
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// ROUND | applying round rnd_idx (0..15), busy high
// DONE  | out_block valid; held until out_ready when OUT_HOLD=1
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter bit OUT_HOLD   = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_block,
  input  logic [55:0]     in_cd,
  input  logic            in_decrypt,
  output logic [LR_W-1:0] rf_r,
  output logic [55:0]     rf_cd,
  input  logic [LR_W-1:0] rf_f,
  output logic [3:0]      rnd_idx,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_block
);

  if (NUM_ROUNDS != DES_ROUNDS) begin : g_bad_rounds
    $error("des_round_ctrl: only NUM_ROUNDS=16 is supported");
  end

  des_state_e      state_q, state_d;
  logic [LR_W-1:0] l_q, l_d, r_q, r_d;
  logic [55:0]     cd_q, cd_d;
  logic [3:0]      rnd_idx_q, rnd_idx_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_block_q, out_block_d;

  logic [1:0]      sh_amt;
  logic            rot_right;
  logic [55:0]     cd_rot;
  logic            last_round;

`ifdef DES_ROUND_CTRL_DECRYPT_EN
  localparam bit DECRYPT_EN = 1'b1;
  logic       mode_q, mode_d;
  logic [3:0] dec_idx;

  // Decrypt walks the encrypt shifts backwards: round i>0 undoes shift SH[16-i].
  always_comb begin
    dec_idx   = 4'd0 - rnd_idx_q;
    rot_right = mode_q;
    if (!mode_q)
      sh_amt = DES_SH[rnd_idx_q];
    else if (rnd_idx_q == 4'd0)
      sh_amt = 2'd0;
    else
      sh_amt = DES_SH[dec_idx];
  end
`else
  localparam bit DECRYPT_EN = 1'b0;
  logic unused_in_decrypt;

  assign unused_in_decrypt = in_decrypt;
  assign rot_right         = 1'b0;
  assign sh_amt            = DES_SH[rnd_idx_q];
`endif

  des_key_rot #(.ALLOW_RIGHT(DECRYPT_EN)) u_rot_c (
    .din      (cd_q[55:28]),
    .amt      (sh_amt),
    .dir_right(rot_right),
    .dout     (cd_rot[55:28])
  );

  des_key_rot #(.ALLOW_RIGHT(DECRYPT_EN)) u_rot_d (
    .din      (cd_q[27:0]),
    .amt      (sh_amt),
    .dir_right(rot_right),
    .dout     (cd_rot[27:0])
  );

  assign last_round = (rnd_idx_q == 4'(NUM_ROUNDS - 1));

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    cd_d        = cd_q;
    rnd_idx_d   = rnd_idx_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
    mode_d      = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          l_d        = in_block[63:32];
          r_d        = in_block[31:0];
          cd_d       = in_cd;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
          mode_d     = in_decrypt;
`endif
          rnd_idx_d  = 4'd0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        l_d  = r_q;
        r_d  = l_q ^ rf_f;
        cd_d = cd_rot;
        if (last_round) begin
          // Output is the pre-FP swap {R16, L16}.
          out_block_d = {l_q ^ rf_f, r_q};
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          rnd_idx_d   = 4'd0;
          state_d     = ST_DONE;
        end else begin
          rnd_idx_d = rnd_idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (!OUT_HOLD || out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        rnd_idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      rnd_idx_q   <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      cd_q        <= cd_d;
      rnd_idx_q   <= rnd_idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // Datapath inputs are forced quiet outside ROUND.
  assign rf_r      = (state_q == ST_ROUND) ? r_q : '0;
  assign rf_cd     = (state_q == ST_ROUND) ? cd_rot : '0;
  assign rnd_idx   = rnd_idx_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule
